weight_tile_sequencer: RTL

//  Upstream driver of the weight-side address generator. On a start command it walks the

---
 rtl/weight_tile_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/weight_tile_sequencer.sv
// Weight-side tile sequencer: walks (iter_t, iter_i) tiles and drives on/base_addr/num_cols.
// Optional cycle counter on perf_cycles when WTS_PERF_CNT_EN is defined.
module weight_tile_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int ARRAY_M    = 8,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [DIM_WIDTH-1:0]       depth,
    input  logic [DIM_WIDTH-1:0]       tiles_i,
    input  logic [DIM_WIDTH-1:0]       tiles_t,
    input  logic [DIM_WIDTH-1:0]       total_cols,
    output logic                       busy,
    output logic                       done,
    output logic                       on,
    output logic [ADDR_WIDTH-1:0]      base_addr,
    output logic [$clog2(ARRAY_M):0]   num_cols
`ifdef WTS_PERF_CNT_EN
    ,
    output logic [31:0]                perf_cycles
`endif
);

    localparam int NC = $clog2(ARRAY_M) + 1;
    localparam logic [DIM_WIDTH-1:0] M_DIM = DIM_WIDTH'(ARRAY_M);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [DIM_WIDTH-1:0]  depth_q, depth_d;
    logic [DIM_WIDTH-1:0]  ti_q, ti_d;
    logic [DIM_WIDTH-1:0]  tt_q, tt_d;
    logic [DIM_WIDTH-1:0]  rem_q, rem_d;
    logic [DIM_WIDTH-1:0]  iter_i_q, iter_i_d;
    logic [DIM_WIDTH-1:0]  iter_t_q, iter_t_d;
    logic [DIM_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [NC-1:0]         ncols_q, ncols_d;

    logic [DIM_WIDTH-1:0]  rem_nx;
    logic [DIM_WIDTH-1:0]  gap_len;
    logic                  last_i, last_t;

    function automatic logic [NC-1:0] min_cols(input logic [DIM_WIDTH-1:0] r);
        if (r >= M_DIM) return NC'(ARRAY_M);
        return NC'(r);
    endfunction

    // Remaining columns never underflow; a short final tile just reads 0.
    assign rem_nx  = (rem_q > M_DIM) ? rem_q - M_DIM : '0;
    assign last_i  = (iter_i_q == ti_q - 1'b1);
    assign last_t  = mode_q || (iter_t_q == tt_q - 1'b1);
    assign gap_len = (mode_q && ncols_q != '0) ? DIM_WIDTH'(ncols_q)
                                               : DIM_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        depth_d  = depth_q;
        ti_d     = ti_q;
        tt_d     = tt_q;
        rem_d    = rem_q;
        iter_i_d = iter_i_q;
        iter_t_d = iter_t_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        ncols_d  = ncols_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    depth_d  = depth;
                    ti_d     = tiles_i;
                    tt_d     = tiles_t;
                    rem_d    = total_cols;
                    ncols_d  = min_cols(total_cols);
                    iter_i_d = '0;
                    iter_t_d = '0;
                    cnt_d    = '0;
                    base_d   = '0;
                    if (depth == '0 || tiles_i == '0 ||
                        (!mode && tiles_t == '0))
                        state_d = FIN;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == depth_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == gap_len - 1'b1) begin
                    cnt_d = '0;
                    if (last_i && last_t) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        // One running sum covers both inner steps and outer wraps.
                        base_d  = base_q + ADDR_WIDTH'(depth_q);
                        if (last_i) begin
                            iter_i_d = '0;
                            iter_t_d = iter_t_q + 1'b1;
                            rem_d    = rem_nx;
                            ncols_d  = min_cols(rem_nx);
                        end else begin
                            iter_i_d = iter_i_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            depth_q  <= '0;
            ti_q     <= '0;
            tt_q     <= '0;
            rem_q    <= '0;
            iter_i_q <= '0;
            iter_t_q <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            ncols_q  <= NC'(ARRAY_M);
            on       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            depth_q  <= depth_d;
            ti_q     <= ti_d;
            tt_q     <= tt_d;
            rem_q    <= rem_d;
            iter_i_q <= iter_i_d;
            iter_t_q <= iter_t_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            ncols_q  <= ncols_d;
            on       <= (state_d == RUN);
            busy     <= (state_d == RUN) || (state_d == GAP);
            done     <= (state_d == FIN);
        end
    end

    assign base_addr = base_q;
    assign num_cols  = ncols_q;

`ifdef WTS_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_cycles <= '0;
        else if (state_q == IDLE && start)
            perf_cycles <= '0;
        else if (state_q != IDLE && perf_cycles != '1)
            perf_cycles <= perf_cycles + 1'b1;
    end
`endif

endmodule
